// File: rtl/branch_target_predictor.sv
// Bimodal direction predictor plus direct-mapped branch target buffer.
// Ports: clk, rst (sync, active-high), fetchPc -> branchPredict,
//   predictorReady, and the resolved-branch training port update*.
//   branchPredict packs {isBranchTakenPredicted, isNextPcPredicted,
//   predictedNextPC} from MSB to LSB.
module branch_target_predictor #(
   parameter int ENTRY_NUM  = 64,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] fetchPc,
   output logic [ADDR_WIDTH+1:0] branchPredict,
   output logic                  predictorReady,
   input  logic                  updateEn,
   input  logic [ADDR_WIDTH-1:0] updatePc,
   input  logic                  updateIsTaken,
   input  logic [ADDR_WIDTH-1:0] updateTarget
);

   localparam int INDEX_WIDTH = $clog2(ENTRY_NUM);
   localparam int TAG_WIDTH   = ADDR_WIDTH - INDEX_WIDTH - 2;
   localparam logic [INDEX_WIDTH-1:0] LAST_IDX =
      INDEX_WIDTH'(ENTRY_NUM - 1);

   typedef enum logic {
      INIT,
      READY
   } state_t;

   state_t                 state_q;
   state_t                 state_d;
   logic [INDEX_WIDTH-1:0] init_idx_q;
   logic [INDEX_WIDTH-1:0] init_idx_d;

   // Table storage; deliberately not reset so it can map onto RAM.
   // The init sweep is what clears it.
   logic                  valid_q  [ENTRY_NUM];
   logic [TAG_WIDTH-1:0]  tag_q    [ENTRY_NUM];
   logic [1:0]            ctr_q    [ENTRY_NUM];
   logic                  tvalid_q [ENTRY_NUM];
   logic [ADDR_WIDTH-1:0] target_q [ENTRY_NUM];

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= INIT;
         init_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         init_idx_q <= init_idx_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      init_idx_d = init_idx_q;
      unique case (state_q)
         INIT: begin
            init_idx_d = init_idx_q + INDEX_WIDTH'(1);
            if (init_idx_q == LAST_IDX) begin
               state_d = READY;
            end
         end
         READY: begin
            state_d = READY;
         end
         default: begin
            state_d = INIT;
         end
      endcase
   end

   assign predictorReady = (state_q == READY);

   // ---------------- lookup ----------------
   logic [INDEX_WIDTH-1:0] f_idx;
   logic [TAG_WIDTH-1:0]   f_tag;
   logic                   f_hit;
   logic                   f_taken;
   logic                   f_npv;
   logic [ADDR_WIDTH-1:0]  f_seq;
   logic [ADDR_WIDTH-1:0]  f_npc;

   assign f_idx = fetchPc[INDEX_WIDTH+1:2];
   assign f_tag = fetchPc[ADDR_WIDTH-1:INDEX_WIDTH+2];

   // Lookup is gated by READY so stale or unswept contents never leak out.
   assign f_hit   = predictorReady && valid_q[f_idx]
                    && (tag_q[f_idx] == f_tag);
   assign f_taken = f_hit && ctr_q[f_idx][1];
   assign f_npv   = f_taken && tvalid_q[f_idx];
   assign f_seq   = fetchPc + ADDR_WIDTH'(4);
   assign f_npc   = f_npv ? target_q[f_idx] : f_seq;

   assign branchPredict = {f_taken, f_npv, f_npc};

   // ---------------- update / sweep write ----------------
   logic [INDEX_WIDTH-1:0] u_idx;
   logic [TAG_WIDTH-1:0]   u_tag;
   logic                   u_hit;
   logic [1:0]             u_ctr;

   assign u_idx = updatePc[INDEX_WIDTH+1:2];
   assign u_tag = updatePc[ADDR_WIDTH-1:INDEX_WIDTH+2];
   assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
   assign u_ctr = ctr_q[u_idx];

   logic                   wr_en;
   logic [INDEX_WIDTH-1:0] wr_idx;
   logic                   wr_valid;
   logic [TAG_WIDTH-1:0]   wr_tag;
   logic [1:0]             wr_ctr;
   logic                   wr_tvalid;
   logic [ADDR_WIDTH-1:0]  wr_target;

   // A single write port serves both the sweep and training, so each
   // write is a full read-modify-write of one entry.
   always_comb begin
      wr_en     = 1'b0;
      wr_idx    = u_idx;
      wr_valid  = valid_q[u_idx];
      wr_tag    = tag_q[u_idx];
      wr_ctr    = u_ctr;
      wr_tvalid = tvalid_q[u_idx];
      wr_target = target_q[u_idx];
      if (state_q == INIT) begin
         wr_en     = 1'b1;
         wr_idx    = init_idx_q;
         wr_valid  = 1'b0;
         wr_tag    = '0;
         wr_ctr    = 2'd1;
         wr_tvalid = 1'b0;
         wr_target = '0;
      end else if (updateEn) begin
         unique case (1'b1)
            (u_hit && updateIsTaken): begin
               wr_en     = 1'b1;
               wr_ctr    = (u_ctr == 2'd3) ? 2'd3 : u_ctr + 2'd1;
               wr_tvalid = 1'b1;
               wr_target = updateTarget;
            end
            (u_hit && !updateIsTaken): begin
               wr_en  = 1'b1;
               wr_ctr = (u_ctr == 2'd0) ? 2'd0 : u_ctr - 2'd1;
            end
            (!u_hit && updateIsTaken): begin
               wr_en     = 1'b1;
               wr_valid  = 1'b1;
               wr_tag    = u_tag;
               wr_ctr    = 2'd2;
               wr_tvalid = 1'b1;
               wr_target = updateTarget;
            end
            default: begin
               wr_en = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && wr_en) begin
         valid_q[wr_idx]  <= wr_valid;
         tag_q[wr_idx]    <= wr_tag;
         ctr_q[wr_idx]    <= wr_ctr;
         tvalid_q[wr_idx] <= wr_tvalid;
         target_q[wr_idx] <= wr_target;
      end
   end

   // Byte offset bits take no part in indexing or tagging.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{fetchPc[1:0], updatePc[1:0]};

endmodule

// File: tb/tb_branch_target_predictor.sv
// Self-checking bench for branch_target_predictor.
// Directed steps; expected predictions queued then compared.
module tb_branch_target_predictor;

   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] fetchPc;
   logic [AW+1:0] branchPredict;
   logic          predictorReady;
   logic          updateEn;
   logic [AW-1:0] updatePc;
   logic          updateIsTaken;
   logic [AW-1:0] updateTarget;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string         name;
      logic [AW+1:0] exp;
   } exp_t;

   exp_t sb[$];

   branch_target_predictor #(
      .ENTRY_NUM(64),
      .ADDR_WIDTH(AW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .fetchPc(fetchPc),
      .branchPredict(branchPredict),
      .predictorReady(predictorReady),
      .updateEn(updateEn),
      .updatePc(updatePc),
      .updateIsTaken(updateIsTaken),
      .updateTarget(updateTarget)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic pop_check();
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $error("FAIL sb_empty observed 0 entries expected 1");
      end else begin
         e = sb.pop_front();
         assert (branchPredict === e.exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h",
                   e.name, branchPredict, e.exp);
         end
      end
   endtask

   // Drive a fetch PC, queue its expected bundle, compare mid-cycle.
   task automatic fetch(string n, logic [AW-1:0] pc, logic t,
                        logic v, logic [AW-1:0] npc);
      exp_t e;
      fetchPc = pc;
      e.name  = n;
      e.exp   = {t, v, npc};
      sb.push_back(e);
      #1;
      pop_check();
   endtask

   task automatic check_ready(string n, logic exp);
      checks++;
      assert (predictorReady === exp) else begin
         errors++;
         $error("FAIL %s observed %b expected %b",
                n, predictorReady, exp);
      end
   endtask

   task automatic upd(logic [AW-1:0] pc, logic tk, logic [AW-1:0] tgt);
      updateEn      = 1'b1;
      updatePc      = pc;
      updateIsTaken = tk;
      updateTarget  = tgt;
   endtask

   task automatic cyc();
      @(negedge clk);
      updateEn = 1'b0;
   endtask

   initial begin
      logic [AW-1:0] pc;
      rst           = 1'b1;
      fetchPc       = '0;
      updateEn      = 1'b0;
      updatePc      = '0;
      updateIsTaken = 1'b0;
      updateTarget  = '0;
      cyc();
      check_ready("rst_ready", 1'b0);
      fetch("rst_fetch", 32'h100, 1'b0, 1'b0, 32'h104);
      cyc();
      rst = 1'b0;

      // Init sweep: 64 cycles not ready, lookups always sequential.
      for (int i = 0; i < 64; i++) begin
         check_ready("init_ready", 1'b0);
         pc = $urandom;
         fetch("init_fetch", pc, 1'b0, 1'b0, pc + 32'd4);
         if (i == 10) upd(32'h100, 1'b1, 32'h999);
         cyc();
      end
      check_ready("ready_up", 1'b1);
      fetch("init_upd_ignored", 32'h100, 1'b0, 1'b0, 32'h104);

      // Allocate and predict; same-cycle lookup sees old contents.
      upd(32'h100, 1'b1, 32'h200);
      fetch("alloc_same_cycle", 32'h100, 1'b0, 1'b0, 32'h104);
      cyc();
      fetch("alloc_hit", 32'h100, 1'b1, 1'b1, 32'h200);
      fetch("alloc_neighbour", 32'h104, 1'b0, 1'b0, 32'h108);

      // Saturate at 3, then hysteresis on the way down.
      upd(32'h100, 1'b1, 32'h200); cyc();
      upd(32'h100, 1'b1, 32'h200); cyc();
      upd(32'h100, 1'b1, 32'h200); cyc();
      fetch("sat3", 32'h100, 1'b1, 1'b1, 32'h200);
      upd(32'h100, 1'b0, 32'h0); cyc();
      fetch("hyst_one_nt", 32'h100, 1'b1, 1'b1, 32'h200);
      upd(32'h100, 1'b0, 32'h0); cyc();
      fetch("hyst_two_nt", 32'h100, 1'b0, 1'b0, 32'h104);
      upd(32'h100, 1'b0, 32'h0); cyc();
      upd(32'h100, 1'b0, 32'h0); cyc();
      upd(32'h100, 1'b1, 32'h200); cyc();
      fetch("sat0", 32'h100, 1'b0, 1'b0, 32'h104);
      upd(32'h100, 1'b1, 32'h200); cyc();
      fetch("recover", 32'h100, 1'b1, 1'b1, 32'h200);

      // Alias replacement at index 0.
      upd(32'h200, 1'b1, 32'h300); cyc();
      fetch("alias_old", 32'h100, 1'b0, 1'b0, 32'h104);
      fetch("alias_new", 32'h200, 1'b1, 1'b1, 32'h300);

      // Reallocate 0x100 then same-cycle conflict.
      upd(32'h100, 1'b1, 32'h200); cyc();
      fetch("realloc", 32'h100, 1'b1, 1'b1, 32'h200);
      upd(32'h100, 1'b1, 32'h400);
      fetch("conflict_old", 32'h100, 1'b1, 1'b1, 32'h200);
      cyc();
      fetch("conflict_new", 32'h100, 1'b1, 1'b1, 32'h400);

      // Not-taken miss must not allocate; taken miss does.
      upd(32'h10c, 1'b0, 32'h500); cyc();
      fetch("nt_no_alloc", 32'h10c, 1'b0, 1'b0, 32'h110);
      upd(32'h10c, 1'b1, 32'h500); cyc();
      fetch("alloc_10c", 32'h10c, 1'b1, 1'b1, 32'h500);

      fetch("pc_wrap", 32'hffff_fffc, 1'b0, 1'b0, 32'h0);

      // Mid-operation reset restarts the sweep.
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check_ready("rst2_drop", 1'b0);
      fetch("rst2_init_fetch", 32'h100, 1'b0, 1'b0, 32'h104);
      for (int i = 0; i < 64; i++) begin
         if (i == 63) check_ready("rst2_last_init", 1'b0);
         cyc();
      end
      check_ready("rst2_ready", 1'b1);
      fetch("rst2_cleared", 32'h100, 1'b0, 1'b0, 32'h104);
      fetch("rst2_cleared_10c", 32'h10c, 1'b0, 1'b0, 32'h110);

      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL sb_drain observed %0d expected 0", sb.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
